// File: rtl/bcd_vote_tally.sv
// Synchronous packed-BCD vote tally: one counter per candidate plus a grand total,
// with a sequential scan that reports the winner, its count and whether another candidate ties it.

module bcd_incr #(
    parameter int DIGITS = 6
) (
    input  logic [4*DIGITS-1:0] d,
    output logic [4*DIGITS-1:0] q,
    output logic                carry
);
    // carry out of the top digit means d was all 9s
    always_comb begin
        q     = '0;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (d[4*k +: 4] == 4'd9) begin
                    q[4*k +: 4] = 4'd0;
                end else begin
                    q[4*k +: 4] = d[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                q[4*k +: 4] = d[4*k +: 4];
            end
        end
    end
endmodule

module bcd_vote_tally #(
    parameter int N_CAND   = 5,
    parameter int N_DIGITS = 6,
    parameter int IDX_W    = 3,
    parameter int SATURATE = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      vote_valid,
    input  logic [IDX_W-1:0]          vote_cand,
    output logic                      vote_ready,
    output logic                      bad_vote,
    input  logic                      finish,
    input  logic [IDX_W-1:0]          rd_cand,
    output logic [4*N_DIGITS-1:0]     rd_count,
    output logic [4*(N_DIGITS+1)-1:0] total_count,
    output logic [N_CAND-1:0]         ovf,
    output logic                      result_valid,
    output logic [IDX_W-1:0]          winner,
    output logic [4*N_DIGITS-1:0]     winner_count,
    output logic                      tie
);
    localparam int CW = 4*N_DIGITS;
    localparam int TW = 4*(N_DIGITS+1);
    localparam logic [IDX_W:0] NCAND = (IDX_W+1)'(N_CAND);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [N_CAND-1:0][CW-1:0] cnt;
    logic [TW-1:0]            total_q, total_inc;
    logic                     total_cy;
    logic                     accept, idx_ok, count_en;
    logic [IDX_W:0]           scan_i;
    logic                     scan_vld;
    logic [IDX_W-1:0]         scan_idx;
    logic [CW-1:0]            scan_cnt;

    assign idx_ok       = ({1'b0, vote_cand} < NCAND);
    assign accept       = vote_valid & vote_ready;
    assign count_en     = accept & idx_ok;
    assign result_valid = (state_q == DONE);
    assign total_count  = total_q;
    assign rd_count     = ({1'b0, rd_cand} < NCAND) ? cnt[rd_cand] : '0;

    always_comb begin
        state_d    = state_q;
        vote_ready = 1'b0;
        case (state_q)
            IDLE: begin
                vote_ready = ~clear;
                if (finish) state_d = SCAN;
            end
            SCAN:    if (scan_i == NCAND) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      state_q <= IDLE;
        else if (clear) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // per-candidate lanes
    for (genvar c = 0; c < N_CAND; c++) begin : g_lane
        logic [CW-1:0] cnt_r, inc;
        logic          ovf_r, cy;

        bcd_incr #(.DIGITS(N_DIGITS)) u_inc (.d(cnt_r), .q(inc), .carry(cy));

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_r <= '0;
                ovf_r <= 1'b0;
            end else if (clear) begin
                cnt_r <= '0;
                ovf_r <= 1'b0;
            end else if (count_en && vote_cand == IDX_W'(c)) begin
                cnt_r <= (cy && SATURATE != 0) ? cnt_r : inc;
                if (cy) ovf_r <= 1'b1;
            end
        end

        assign cnt[c] = cnt_r;
        assign ovf[c] = ovf_r;
    end

    bcd_incr #(.DIGITS(N_DIGITS+1)) u_total_inc (.d(total_q), .q(total_inc), .carry(total_cy));

    // scan is two-stage: fetch count[i] into scan_cnt, compare on the next edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total_q      <= '0;
            bad_vote     <= 1'b0;
            scan_i       <= '0;
            scan_vld     <= 1'b0;
            scan_idx     <= '0;
            scan_cnt     <= '0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else if (clear) begin
            total_q      <= '0;
            bad_vote     <= 1'b0;
            scan_i       <= '0;
            scan_vld     <= 1'b0;
            scan_idx     <= '0;
            scan_cnt     <= '0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else begin
            bad_vote <= accept & ~idx_ok;
            if (count_en)
                total_q <= (total_cy && SATURATE != 0) ? total_q : total_inc;

            scan_vld <= 1'b0;
            if (state_q == IDLE) begin
                scan_i <= '0;
            end else if (state_q == SCAN && scan_i != NCAND) begin
                scan_cnt <= cnt[scan_i[IDX_W-1:0]];
                scan_idx <= scan_i[IDX_W-1:0];
                scan_vld <= 1'b1;
                scan_i   <= scan_i + 1'b1;
            end

            if (scan_vld) begin
                if (scan_idx == '0 || scan_cnt > winner_count) begin
                    winner       <= scan_idx;
                    winner_count <= scan_cnt;
                    tie          <= 1'b0;
                end else if (scan_cnt == winner_count) begin
                    tie <= 1'b1;
                end
            end
        end
    end
endmodule
